// File: rtl/move_sequencer.sv
// Move queue and issue sequencer between the solver and the stepper move executor.
// Optional MOVE_CANCEL_EN drops adjacent same-face opposite-direction move pairs before issue.
module move_sequencer #(
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 100000,
  parameter int ARM_TIMEOUT   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               in_move,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     halt,
  output logic [3:0]               next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [15:0]              moves_done,
  output logic                     bad_move
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int ARM_W    = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int ARM_LAST = (ARM_TIMEOUT > 0) ? ARM_TIMEOUT - 1 : 0;
  localparam int SET_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  logic [3:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [2:0]       state_q, state_d;
  logic [3:0]       next_move_q, next_move_d;
  logic             move_start_q, move_start_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [15:0]      moves_done_q, moves_done_d;
  logic             bad_move_q, bad_move_d;

  logic             accept;
  logic             code_ok;
  logic             code_bad;
  logic             push;
  logic [1:0]       pop_n;
  logic [3:0]       head;
  logic             cancel;

  always_comb begin
    accept   = in_valid & in_ready_q;
    code_ok  = (in_move >= 4'd2) && (in_move <= 4'd13);
    code_bad = (in_move == 4'd0) || (in_move == 4'd1) || (in_move == 4'd14);
    push     = accept & code_ok;
    head     = mem_q[rd_ptr_q];
  end

`ifdef MOVE_CANCEL_EN
  logic [3:0] second;
  always_comb begin
    second = mem_q[rd_ptr_q + AW'(1)];
    cancel = (count_q >= CW'(2)) && (head[3:1] == second[3:1]) && (head[0] != second[0]);
  end
`else
  always_comb begin
    cancel = 1'b0;
  end
`endif

  // Cancellation wins over issue and ignores halt; the executor is never involved.
  always_comb begin
    state_d      = state_q;
    next_move_d  = next_move_q;
    arm_cnt_d    = arm_cnt_q;
    settle_cnt_d = settle_cnt_q;
    moves_done_d = moves_done_q;
    pop_n        = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          pop_n = 2'd2;
        end else if ((count_q != '0) && !halt && move_done) begin
          pop_n       = 2'd1;
          next_move_d = head;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_ARM;
        arm_cnt_d = '0;
      end
      ST_ARM: begin
        if (!move_done) begin
          state_d = ST_WAIT;
        end else if (arm_cnt_q == ARM_W'(ARM_LAST)) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      ST_WAIT: begin
        if (move_done) begin
          moves_done_d = moves_done_q + 16'd1;
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SET_W'(SET_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + (push ? AW'(1) : AW'(0));
    rd_ptr_d     = rd_ptr_q + AW'(pop_n);
    count_d      = count_q + CW'(push) - CW'(pop_n);
    in_ready_d   = (count_d != CW'(DEPTH));
    move_start_d = (state_d == ST_ISSUE);
    bad_move_d   = bad_move_q | (accept & code_bad);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      state_q      <= ST_IDLE;
      next_move_q  <= 4'hF;
      move_start_q <= 1'b0;
      arm_cnt_q    <= '0;
      settle_cnt_q <= '0;
      moves_done_q <= '0;
      bad_move_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      state_q      <= state_d;
      next_move_q  <= next_move_d;
      move_start_q <= move_start_d;
      arm_cnt_q    <= arm_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      moves_done_q <= moves_done_d;
      bad_move_q   <= bad_move_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_move;
    end
  end

  assign in_ready    = in_ready_q;
  assign next_move   = next_move_q;
  assign move_start  = move_start_q;
  assign busy        = (state_q != ST_IDLE);
  assign queue_count = count_q;
  assign moves_done  = moves_done_q;
  assign bad_move    = bad_move_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios plus random traffic against a queue-based reference model.
module tb_move_sequencer;

  localparam int DEPTH   = 16;
  localparam int SETTLE  = 4;
  localparam int ARM_TO  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_move = 4'd15;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       halt = 1'b0;
  logic [3:0] next_move;
  logic       move_start;
  logic       move_done = 1'b1;
  logic       busy;
  logic [4:0] queue_count;
  logic [15:0] moves_done;
  logic       bad_move;

  move_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .ARM_TIMEOUT(ARM_TO)) dut (
    .clock(clock), .reset(reset), .in_move(in_move), .in_valid(in_valid),
    .in_ready(in_ready), .halt(halt), .next_move(next_move), .move_start(move_start),
    .move_done(move_done), .busy(busy), .queue_count(queue_count),
    .moves_done(moves_done), .bad_move(bad_move)
  );

  initial forever #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a plain queue plus a phase with a remaining-cycles countdown.
  typedef enum {M_IDLE, M_START, M_ARMING, M_RUNNING, M_SETTLING} mphase_t;
  int          m_q[$];
  mphase_t     m_phase = M_IDLE;
  int          m_left = 0;
  int          m_next = 15;
  logic [15:0] m_moves = '0;
  bit          m_bad = 0;
  bit          m_ready = 0;

`ifdef MOVE_CANCEL_EN
  function automatic bit cancels(input int a, input int b);
    return ((a >> 1) == (b >> 1)) && ((a & 1) != (b & 1));
  endfunction
`endif

  task automatic modelStep();
    bit acc;
    bit cancel_now;
    int code;
    int settle_len;
    acc = in_valid && m_ready;
    code = int'(in_move);
    settle_len = (SETTLE > 0) ? SETTLE : 1;
    if (reset) begin
      m_q.delete();
      m_phase = M_IDLE;
      m_left  = 0;
      m_next  = 15;
      m_moves = '0;
      m_bad   = 0;
      m_ready = 0;
      return;
    end
    case (m_phase)
      M_IDLE: begin
        cancel_now = 0;
`ifdef MOVE_CANCEL_EN
        if (m_q.size() >= 2) cancel_now = cancels(m_q[0], m_q[1]);
`endif
        if (cancel_now) begin
          void'(m_q.pop_front());
          void'(m_q.pop_front());
        end else if (m_q.size() > 0 && !halt && move_done) begin
          m_next  = m_q.pop_front();
          m_phase = M_START;
        end
      end
      M_START: begin
        m_phase = M_ARMING;
        m_left  = ARM_TO;
      end
      M_ARMING: begin
        if (!move_done) m_phase = M_RUNNING;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_phase = M_SETTLING;
            m_left  = settle_len;
          end
        end
      end
      M_RUNNING: begin
        if (move_done) begin
          m_moves++;
          m_phase = M_SETTLING;
          m_left  = settle_len;
        end
      end
      M_SETTLING: begin
        m_left--;
        if (m_left == 0) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    if (acc && code >= 2 && code <= 13) m_q.push_back(code);
    if (acc && (code <= 1 || code == 14)) m_bad = 1;
    m_ready = (m_q.size() < DEPTH);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    modelStep();
    chk_en = 1;
  end

  // Per-cycle comparison against the model, plus observation counters for directed checks.
  int start_cnt = 0;
  int issued[$];
  int peak_cnt = 0;
  int busy_cycles = 0;
  int busy_fall_cyc = 0;
  bit prev_busy = 0;

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      checkOutput("in_ready",    32'(in_ready),    32'(m_ready));
      checkOutput("move_start",  32'(move_start),  32'(m_phase == M_START));
      checkOutput("busy",        32'(busy),        32'(m_phase != M_IDLE));
      checkOutput("next_move",   32'(next_move),   32'(m_next));
      checkOutput("queue_count", 32'(queue_count), 32'(m_q.size()));
      checkOutput("moves_done",  32'(moves_done),  32'(m_moves));
      checkOutput("bad_move",    32'(bad_move),    32'(m_bad));
      if (move_start) begin
        start_cnt++;
        issued.push_back(int'(next_move));
      end
      if (int'(queue_count) > peak_cnt) peak_cnt = int'(queue_count);
      if (busy) busy_cycles++;
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
    end
  end

  // Executor model: drops move_done some cycles after a start, raises it after the run time.
  int ex_fall_dly = 2;
  int ex_run_len  = 10;
  bit ex_stuck    = 0;
  bit ex_rand     = 0;
  bit ext_en      = 0;
  int ex_fall_left = 0;
  int ex_run_left  = 0;
  int ext_left     = 0;
  int ex_rise_cyc  = 0;
  int ex_run_next  = 0;

  initial forever begin
    @(negedge clock);
    if (move_start) begin
      ext_left = 0;
      if (ex_rand ? ($urandom_range(0, 9) != 0) : !ex_stuck) begin
        ex_fall_left = ex_rand ? int'($urandom_range(1, 4)) : ex_fall_dly;
        ex_run_next  = ex_rand ? int'($urandom_range(1, 12)) : ex_run_len;
      end
    end else if (ex_fall_left > 0) begin
      ex_fall_left--;
      if (ex_fall_left == 0) begin
        move_done   = 1'b0;
        ex_run_left = ex_run_next;
      end
    end else if (ex_run_left > 0) begin
      ex_run_left--;
      if (ex_run_left == 0) begin
        move_done   = 1'b1;
        ex_rise_cyc = cyc;
      end
    end else if (ext_left > 0) begin
      ext_left--;
      if (ext_left == 0) move_done = 1'b1;
    end else if (ext_en && $urandom_range(0, 99) < 2) begin
      move_done = 1'b0;
      ext_left  = $urandom_range(1, 5);
    end
  end

  task automatic applyStimulus(input logic valid, input logic [3:0] code);
    in_valid = valid;
    in_move  = code;
    @(negedge clock);
  endtask

  task automatic waitIdle(input int limit, input string tag);
    int n;
    n = 0;
    while (!(m_phase == M_IDLE && m_q.size() == 0 && ex_fall_left == 0 &&
             ex_run_left == 0 && ext_left == 0) && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (n >= limit) checkOutput(tag, 0, 1);
    repeat (5) @(negedge clock);
    #1;
  endtask

  int fill_codes[17] = '{2, 4, 6, 8, 10, 12, 3, 5, 7, 9, 11, 13, 2, 4, 6, 8, 10};
  int s0;
  int n_wait;
  int r;

  initial begin
    // Reset values
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("rst_in_ready",    32'(in_ready), 0);
    checkOutput("rst_next_move",   32'(next_move), 15);
    checkOutput("rst_move_start",  32'(move_start), 0);
    checkOutput("rst_busy",        32'(busy), 0);
    checkOutput("rst_queue_count", 32'(queue_count), 0);
    checkOutput("rst_moves_done",  32'(moves_done), 0);
    checkOutput("rst_bad_move",    32'(bad_move), 0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);

    // Single move with a 2-cycle fall and 10-cycle run
    @(negedge clock);
    issued.delete();
    s0 = start_cnt;
    applyStimulus(1'b1, 4'd2);
    in_valid = 1'b0;
    waitIdle(300, "single_timeout");
    checkOutput("single_starts", 32'(start_cnt - s0), 1);
    checkOutput("single_code", 32'(issued.size() > 0 ? issued[0] : -1), 2);
    checkOutput("single_moves_done", 32'(moves_done), 1);
    checkOutput("single_busy_fall", 32'(busy_fall_cyc - ex_rise_cyc), 5);

    // Fill under halt, then drain in order
    halt = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_move  = 4'(fill_codes[i]);
      if (i == 16) begin
        #1;
        checkOutput("full_in_ready", 32'(in_ready), 0);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("full_count", 32'(queue_count), 16);
    issued.delete();
    s0 = start_cnt;
    halt = 1'b0;
    waitIdle(2000, "drain_timeout");
    checkOutput("drain_starts", 32'(start_cnt - s0), 16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("drain_order_%0d", i), 32'(issued.size() > i ? issued[i] : -1), 32'(fill_codes[i]));
    checkOutput("drain_moves_done", 32'(moves_done), 17);

    // Filtering of NULL and illegal codes
    checkOutput("filter_bad_before", 32'(bad_move), 0);
    issued.delete();
    peak_cnt = 0;
    s0 = start_cnt;
    applyStimulus(1'b1, 4'd15);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'd14);
    applyStimulus(1'b1, 4'd4);
    in_valid = 1'b0;
    waitIdle(300, "filter_timeout");
    checkOutput("filter_peak", 32'(peak_cnt), 1);
    checkOutput("filter_starts", 32'(start_cnt - s0), 1);
    checkOutput("filter_code", 32'(issued.size() > 0 ? issued[0] : -1), 4);
    checkOutput("filter_bad_move", 32'(bad_move), 1);

    // Arm timeout: executor never reacts
    ex_stuck = 1;
    busy_cycles = 0;
    applyStimulus(1'b1, 4'd8);
    in_valid = 1'b0;
    waitIdle(300, "arm_timeout_wait");
    checkOutput("arm_busy_cycles", 32'(busy_cycles), 32'(1 + ARM_TO + SETTLE));
    checkOutput("arm_moves_done", 32'(moves_done), 18);
    checkOutput("arm_bad_sticky", 32'(bad_move), 1);
    ex_stuck = 0;

    // Reset while waiting on the executor with three moves queued
    ex_run_len = 40;
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd4);
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b1, 4'd8);
    in_valid = 1'b0;
    n_wait = 0;
    while (m_phase != M_RUNNING && n_wait < 100) begin
      @(negedge clock);
      n_wait++;
    end
    if (n_wait >= 100) checkOutput("midwait_timeout", 0, 1);
    #1;
    checkOutput("midwait_count", 32'(queue_count), 3);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("midrst_count", 32'(queue_count), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_next_move", 32'(next_move), 15);
    checkOutput("midrst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    s0 = start_cnt;
    repeat (60) @(negedge clock);
    #1;
    checkOutput("midrst_no_start", 32'(start_cnt - s0), 0);
    checkOutput("midrst_moves_done", 32'(moves_done), 0);
    waitIdle(300, "midrst_idle_timeout");
    ex_run_len = 10;

    // Opposite-direction pair on the same face
    issued.delete();
    halt = 1'b1;
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'd12);
    in_valid = 1'b0;
    @(negedge clock);
    halt = 1'b0;
    waitIdle(500, "cancel_timeout");
`ifdef MOVE_CANCEL_EN
    checkOutput("cancel_issued", 32'(issued.size()), 1);
    checkOutput("cancel_code", 32'(issued.size() > 0 ? issued[0] : -1), 12);
    checkOutput("cancel_moves_done", 32'(moves_done), 1);
`else
    checkOutput("nocancel_issued", 32'(issued.size()), 3);
    checkOutput("nocancel_code0", 32'(issued.size() > 0 ? issued[0] : -1), 6);
    checkOutput("nocancel_code1", 32'(issued.size() > 1 ? issued[1] : -1), 7);
    checkOutput("nocancel_code2", 32'(issued.size() > 2 ? issued[2] : -1), 12);
    checkOutput("nocancel_moves_done", 32'(moves_done), 3);
`endif

    // Random traffic: codes, halt, executor timing, external busy and occasional reset
    ex_rand = 1;
    ext_en  = 1;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) < 5) halt = ~halt;
      in_valid = ($urandom_range(0, 99) < 40);
      r = $urandom_range(0, 99);
      if (r < 80) in_move = 4'($urandom_range(2, 13));
      else if (r < 90) in_move = 4'd15;
      else begin
        case ($urandom_range(0, 2))
          0: in_move = 4'd0;
          1: in_move = 4'd1;
          default: in_move = 4'd14;
        endcase
      end
      @(negedge clock);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    halt     = 1'b0;
    ext_en   = 0;
    ex_rand  = 0;
    waitIdle(3000, "random_drain_timeout");
    checkOutput("final_count", 32'(queue_count), 0);
    checkOutput("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Queues cube moves from the solver and feeds them one at a time to the stepper move executor (`move_to_step`). It drives `next_move` and `move_start`, and waits for the executor's `move_done` to fall and then rise again. After each move it inserts a mechanical settle interval before starting the next one. It sits between the solution generator and the six-motor stepper front end, and is the only source of `move_start`.

## Interface
Parameters:
- `DEPTH`, 16: queue entries; power of 2, at least 2.
- `SETTLE_CYCLES`, 100000: idle clocks after each move completes (1 ms at 100 MHz); 0 is legal.
- `ARM_TIMEOUT`, 16: maximum clocks to wait for `move_done` to fall after `move_start`.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_move` in 4: move code (2..13 = R,Ri,U,Ui,F,Fi,L,Li,B,Bi,D,Di; 15 = NULL).
- `in_valid` in 1: `in_move` is valid.
- `in_ready` out 1: queue can accept; equals !full.
- `halt` in 1: when high, no new move is issued; a move already in flight completes.
- `next_move` out 4: move code to the executor; held stable from ISSUE through the end of SETTLE.
- `move_start` out 1: one-cycle pulse that starts the executor.
- `move_done` in 1: executor idle level; high when all motors are idle.
- `busy` out 1: high whenever state is not IDLE.
- `queue_count` out clog2(DEPTH)+1: number of occupied entries.
- `moves_done` out 16: count of completed physical moves; wraps 0xFFFF -> 0.
- `bad_move` out 1: sticky; set when codes 0, 1 or 14 are received.

## Operation
- Accept: on `in_valid & in_ready`:
  - Codes 2..13 are written to the tail.
  - NULL (15) is accepted and discarded; it is not queued.
  - Codes 0, 1 and 14 are accepted and discarded, and `bad_move` is set.
- A full queue forces `in_ready` = 0. There is no bypass when a pop happens in the same cycle.
- FSM states: IDLE, ISSUE, ARM, WAIT, SETTLE.
- IDLE:
  - If `queue_count` > 0, `halt` = 0 and `move_done` = 1: pop the head into `next_move` and go to ISSUE.
  - If `move_done` = 0 in IDLE, stay in IDLE (the executor is still busy from elsewhere).
- ISSUE: `move_start` = 1 for exactly this cycle; go to ARM and clear the arm counter.
- ARM:
  - If `move_done` = 0, go to WAIT.
  - Otherwise, once the arm counter reaches `ARM_TIMEOUT`-1, go directly to SETTLE; `moves_done` is not incremented.
- WAIT: when `move_done` = 1, increment `moves_done` and go to SETTLE. No timeout applies.
- SETTLE: count `SETTLE_CYCLES` clocks, then go to IDLE. If `SETTLE_CYCLES` = 0, SETTLE lasts one cycle.
- `halt` changes only IDLE behaviour.
- Reset mid-move:
  - The queue is emptied and the FSM returns to IDLE; `next_move` is set to 15 and `move_start` to 0.
  - The executor is not otherwise told. Its own start gating already ignores `move_start` during reset.
- Pointers are clog2(DEPTH) bits and wrap naturally. Full is `count` == `DEPTH`; empty is `count` == 0.
- A write and a pop in the same cycle leave `count` unchanged.

## Timing
- Reset values (at the first edge with `reset` high):
  - `in_ready` 0, then 1 from the cycle after `reset` is released.
  - `next_move` 15, `move_start` 0, `busy` 0, `queue_count` 0, `moves_done` 0, `bad_move` 0.
- A write at edge k gives `queue_count` ≥ 1 after k. If IDLE, `halt` = 0 and `move_done` = 1, `move_start` is high during the cycle after edge k+1 (2-cycle latency).
- `next_move` is valid in the same cycle as `move_start` and does not change until IDLE is re-entered.
- Minimum gap from the `move_start` of one move to the next: 1 (ISSUE) + arm time + executor time + max(`SETTLE_CYCLES`,1) + 1 (IDLE).
- `queue_count` and `in_ready` are registered and update on the edge of a write or pop.

## Configuration
- `MOVE_CANCEL_EN` defined: in IDLE, if `queue_count` ≥ 2 and the head and second entries are the same face (code[3:1] equal) with opposite direction (code[0] different):
  - Both entries are popped in one cycle and no move is issued; the FSM stays in IDLE.
  - `moves_done` is unchanged.
  - Cancellation is re-evaluated on the next cycle.
  - Cancellation is evaluated regardless of `halt`.
- `MOVE_CANCEL_EN` undefined: entries are always popped one at a time and issued in order.

## Test plan
- Single move: write R (2), with `move_done` model falling 2 cycles after start and rising 10 cycles later, `SETTLE_CYCLES`=4:
  - one `move_start` pulse with `next_move`=2;
  - `moves_done`=1;
  - `busy` falls exactly 5 cycles after `move_done` rises.
- Fill and drain:
  - write 17 moves back-to-back with `DEPTH`=16 while `halt`=1 → 16 are accepted and `in_ready`=0 at the 17th;
  - release `halt` → 16 `move_start` pulses in write order, `moves_done`=16.
- Filtering: write 15, 0, 14, U(4) → only U is issued, `queue_count` peaks at 1, `bad_move`=1 and remains set until reset.
- Arm timeout: `move_done` held at 1 → after ISSUE the FSM spends exactly `ARM_TIMEOUT` cycles in ARM, then SETTLE, with `moves_done` unchanged.
- Reset mid-WAIT with 3 moves queued → next cycle `queue_count`=0, `busy`=0, `next_move`=15, and no further `move_start`.
- With `MOVE_CANCEL_EN`, queue F(6), Fi(7), D(12):
  - only D is issued and `moves_done`=1;
  - without the macro, 6, 7 and 12 are all issued and `moves_done`=3.
